mem_stage_sequencer: RTL and testbench

- MEM-stage consumer of the decoded control word.
- Turns the EX/MEM-latched mem_read, mem_write and opcode into D-memory transactions, including the two-access LDI/STI indirect sequences and LDB/STB byte lanes.
- Drives a stall to the pipeline-load logic until the memory operation completes.
- Sits between the EX/MEM register and the D-memory port.

---
 rtl/mem_stage_sequencer_pkg.sv | 29 ++
 rtl/byte_lane_unit.sv | 24 ++
 rtl/mem_stage_sequencer.sv | 98 +++++++++
 tb/tb_mem_stage_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_sequencer_pkg.sv
// lc3b_types: shared LC-3b opcode constants, MEM-stage sequencer state and byte-enable codes.
// Contents: lc3b_opcode and op_* constants, mseq_state_t (IDLE/ACC1/ACC2/HOLD),
// BE_WORD/BE_LO/BE_HI byte enables, is_indirect() helper for LDI/STI.
package lc3b_types;
  typedef logic [3:0] lc3b_opcode;
  localparam lc3b_opcode op_br   = 4'b0000;
  localparam lc3b_opcode op_add  = 4'b0001;
  localparam lc3b_opcode op_ldb  = 4'b0010;
  localparam lc3b_opcode op_stb  = 4'b0011;
  localparam lc3b_opcode op_jsr  = 4'b0100;
  localparam lc3b_opcode op_and  = 4'b0101;
  localparam lc3b_opcode op_ldr  = 4'b0110;
  localparam lc3b_opcode op_str  = 4'b0111;
  localparam lc3b_opcode op_rti  = 4'b1000;
  localparam lc3b_opcode op_not  = 4'b1001;
  localparam lc3b_opcode op_ldi  = 4'b1010;
  localparam lc3b_opcode op_sti  = 4'b1011;
  localparam lc3b_opcode op_jmp  = 4'b1100;
  localparam lc3b_opcode op_shf  = 4'b1101;
  localparam lc3b_opcode op_lea  = 4'b1110;
  localparam lc3b_opcode op_trap = 4'b1111;
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, HOLD} mseq_state_t;
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  function automatic logic is_indirect(input lc3b_opcode op);
    return op == op_ldi || op == op_sti;
  endfunction
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: combinational LDB byte extraction, STB data replication and byte-enable generation.
// Ports: opcode (in), addr_lsb (in, 1 = high byte), wdata_in/rdata_in (in),
// byte_en (out, bit0 = low byte), wdata_out (out), rdata_out (out, zero-extended byte for LDB).
module byte_lane_unit
  import lc3b_types::*;
#(
  parameter int DATA_W = 16
) (
  input  lc3b_opcode        opcode,
  input  logic              addr_lsb,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic [1:0]        byte_en,
  output logic [DATA_W-1:0] wdata_out,
  output logic [DATA_W-1:0] rdata_out
);
  localparam int H = DATA_W / 2;
  logic [H-1:0] rbyte;
  assign rbyte     = addr_lsb ? rdata_in[DATA_W-1:H] : rdata_in[H-1:0];
  assign rdata_out = opcode == op_ldb ? {{H{1'b0}}, rbyte} : rdata_in;
  // the store byte is placed on both lanes so memory picks it up from whichever lane is enabled
  assign wdata_out = opcode == op_stb ? {2{wdata_in[H-1:0]}} : wdata_in;
  assign byte_en   = opcode == op_stb ? (addr_lsb ? BE_HI : BE_LO) : BE_WORD;
endmodule

// File: rtl/mem_stage_sequencer.sv
// mem_stage_sequencer: MEM-stage sequencer turning EX/MEM control into D-memory transactions
// (single accesses, two-access LDI/STI, LDB/STB byte lanes) and stalling the pipeline until done.
// Inputs : clk, rst_n (async active-low), op_valid, opcode, ctrl_mem_read, ctrl_mem_write,
//          mem_addr, mem_wdata, advance, dmem_resp, dmem_rdata.
// Outputs: dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en, load_data, stall,
//          plus mem_timeout when built with MEM_TIMEOUT_EN (255-cycle access watchdog).
module mem_stage_sequencer
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [3:0]        opcode,
  input  logic              ctrl_mem_read,
  input  logic              ctrl_mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              advance,
  input  logic              dmem_resp,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_en,
  output logic [DATA_W-1:0] load_data,
`ifdef MEM_TIMEOUT_EN
  output logic              mem_timeout,
`endif
  output logic              stall
);
  mseq_state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] data_q;
  logic mem_op, ind, in_acc, active, timeout, ptr_step, complete, is_write;
  logic [1:0] lane_be;
  logic [DATA_W-1:0] lane_wdata, lane_rdata, final_data;
  assign mem_op = op_valid && (ctrl_mem_read || ctrl_mem_write);
  assign ind    = is_indirect(opcode);
  assign in_acc = state_q == ACC1 || state_q == ACC2;
  // requests come straight out of IDLE so an op costs no idle bubble; rst_n gating drops them instantly
  assign active = rst_n && (in_acc || (state_q == IDLE && mem_op));
`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      tmo_cnt <= '0;
    else
      tmo_cnt <= (dmem_resp || state_d != state_q) ? 8'd0 : in_acc ? tmo_cnt + 8'd1 : tmo_cnt;
  assign timeout     = in_acc && tmo_cnt == 8'hFF && !dmem_resp;
  assign mem_timeout = rst_n && timeout;
`else
  assign timeout = 1'b0;
`endif
  // a response to the pointer fetch of LDI/STI moves on to the second access instead of completing
  assign ptr_step   = state_q == ACC1 && ind && dmem_resp;
  assign complete   = rst_n && in_acc && (timeout || (dmem_resp && !ptr_step));
  assign is_write   = state_q == ACC2 ? opcode == op_sti : ctrl_mem_write && !ind;
  byte_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .opcode   (opcode),
    .addr_lsb (mem_addr[0]),
    .wdata_in (mem_wdata),
    .rdata_in (dmem_rdata),
    .byte_en  (lane_be),
    .wdata_out(lane_wdata),
    .rdata_out(lane_rdata)
  );
  assign final_data   = timeout ? DATA_W'(16'hDEAD) : lane_rdata;
  assign dmem_read    = active && !is_write;
  assign dmem_write   = active && is_write;
  assign dmem_addr    = active ? (state_q == ACC2 ? ptr_q : mem_addr) : '0;
  assign dmem_wdata   = dmem_write ? lane_wdata : '0;
  assign dmem_byte_en = dmem_write ? lane_be : BE_WORD;
  assign load_data    = complete ? final_data : (rst_n && state_q == HOLD) ? data_q : '0;
  assign stall        = active && !complete;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       state_d = mem_op ? ACC1 : IDLE;
      ACC1, ACC2: state_d = ptr_step ? ACC2 : complete ? (advance ? IDLE : HOLD) : state_q;
      HOLD:       state_d = advance ? IDLE : HOLD;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ptr_step) ptr_q <= dmem_rdata[ADDR_W-1:0];
      if (complete && !advance) data_q <= final_data;
    end
endmodule

// File: tb/tb_mem_stage_sequencer.sv
// tb_mem_stage_sequencer: table-driven, scoreboarded bench for mem_stage_sequencer.
module tb_mem_stage_sequencer;
  import lc3b_types::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic op_valid = 1'b0, ctrl_mem_read = 1'b0, ctrl_mem_write = 1'b0, advance = 1'b1, dmem_resp = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [15:0] mem_addr = '0, mem_wdata = '0, dmem_rdata = '0;
  logic dmem_read, dmem_write, stall;
  logic [15:0] dmem_addr, dmem_wdata, load_data;
  logic [1:0] dmem_byte_en;
`ifdef MEM_TIMEOUT_EN
  logic mem_timeout;
`endif
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mem_stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .opcode(opcode),
    .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_write(ctrl_mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .advance(advance),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en), .load_data(load_data),
`ifdef MEM_TIMEOUT_EN
    .mem_timeout(mem_timeout),
`endif
    .stall(stall)
  );
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
  } acc_t;
  typedef struct {
    logic [3:0]  op;
    logic        rd, wr;
    logic [15:0] addr, wdata, r1, r2;
    int          l1, l2;
    logic        ind;
    acc_t        a1, a2;
    logic        chk_ld;
    logic [15:0] exp_ld;
  } vec_t;
  acc_t sb[$];
  logic [15:0] ld_q[$];
  vec_t v[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_read"}, dmem_read, 0);
    chk({tag, "_write"}, dmem_write, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_load"}, load_data, 0);
    chk({tag, "_be"}, dmem_byte_en, 2'b11);
  endtask
  task automatic idle_chk(input string tag);
    op_valid = 1'b0; dmem_resp = 1'b0; advance = 1'b1;
    #2;
    chk({tag, "_idle_req"}, {dmem_read, dmem_write}, 0);
    chk({tag, "_idle_stall"}, stall, 0);
    @(negedge clk);
  endtask
  task automatic run_vec(input vec_t t, input logic adv);
    acc_t e;
    logic [1:0] rq_k;
    logic [15:0] rq_a;
    int na, lat;
    logic fin;
    sb.push_back(t.a1);
    if (t.ind) sb.push_back(t.a2);
    if (t.chk_ld) ld_q.push_back(t.exp_ld);
    op_valid = 1'b1; opcode = t.op; ctrl_mem_read = t.rd; ctrl_mem_write = t.wr;
    mem_addr = t.addr; mem_wdata = t.wdata; advance = adv;
    na = t.ind ? 2 : 1;
    rq_k = '0; rq_a = '0;
    for (int a = 0; a < na; a++) begin
      lat = a == 0 ? t.l1 : t.l2;
      for (int c = 0; c < lat; c++) begin
        fin = (a == na - 1) && (c == lat - 1);
        dmem_resp = c == lat - 1;
        dmem_rdata = a == 0 ? t.r1 : t.r2;
        #2;
        if (c == 0) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("req_kind", {dmem_read, dmem_write}, {~e.wr, e.wr});
            chk("req_addr", dmem_addr, e.addr);
            if (e.wr) begin
              chk("req_be", dmem_byte_en, e.be);
              chk("req_wdata", dmem_wdata, e.wd);
            end
          end
          rq_k = {dmem_read, dmem_write};
          rq_a = dmem_addr;
        end else chk("req_hold", {dmem_read, dmem_write, dmem_addr}, {rq_k, rq_a});
        chk("stall", stall, !fin);
        if (fin && t.chk_ld) chk("load_data", load_data, ld_q.pop_front());
        @(negedge clk);
      end
    end
    dmem_resp = 1'b0;
  endtask
  initial begin
    //      op       rd wr addr      wdata     r1        r2        l1 l2 ind a1                              a2                              ld exp
    v[0] = '{op_ldr,  1, 0, 16'h0040, 16'h0000, 16'h1234, 16'h0000, 3, 0, 0, '{0, 16'h0040, 2'b11, 16'h0000}, '{0, 16'h0000, 2'b11, 16'h0000}, 1, 16'h1234};
    v[1] = '{op_ldi,  1, 0, 16'h0010, 16'h0000, 16'h0200, 16'hBEEF, 2, 2, 1, '{0, 16'h0010, 2'b11, 16'h0000}, '{0, 16'h0200, 2'b11, 16'h0000}, 1, 16'hBEEF};
    v[2] = '{op_sti,  0, 1, 16'h0010, 16'hCAFE, 16'h0300, 16'h0000, 2, 3, 1, '{0, 16'h0010, 2'b11, 16'h0000}, '{1, 16'h0300, 2'b11, 16'hCAFE}, 0, 16'h0000};
    v[3] = '{op_stb,  0, 1, 16'h0021, 16'h00A5, 16'h0000, 16'h0000, 2, 0, 0, '{1, 16'h0021, 2'b10, 16'hA5A5}, '{0, 16'h0000, 2'b11, 16'h0000}, 0, 16'h0000};
    v[4] = '{op_ldb,  1, 0, 16'h0021, 16'h0000, 16'hA5A5, 16'h0000, 2, 0, 0, '{0, 16'h0021, 2'b11, 16'h0000}, '{0, 16'h0000, 2'b11, 16'h0000}, 1, 16'h00A5};
    v[5] = '{op_ldb,  1, 0, 16'h0020, 16'h0000, 16'h12AB, 16'h0000, 3, 0, 0, '{0, 16'h0020, 2'b11, 16'h0000}, '{0, 16'h0000, 2'b11, 16'h0000}, 1, 16'h00AB};
    v[6] = '{op_str,  0, 1, 16'h0100, 16'h5555, 16'h0000, 16'h0000, 4, 0, 0, '{1, 16'h0100, 2'b11, 16'h5555}, '{0, 16'h0000, 2'b11, 16'h0000}, 0, 16'h0000};
    v[7] = '{op_trap, 1, 0, 16'h0002, 16'h0000, 16'h4000, 16'h0000, 2, 0, 0, '{0, 16'h0002, 2'b11, 16'h0000}, '{0, 16'h0000, 2'b11, 16'h0000}, 1, 16'h4000};
    v[8] = '{op_stb,  0, 1, 16'h0030, 16'h1234, 16'h0000, 16'h0000, 2, 0, 0, '{1, 16'h0030, 2'b01, 16'h3434}, '{0, 16'h0000, 2'b11, 16'h0000}, 0, 16'h0000};
    v[9] = '{op_ldi,  1, 0, 16'h0050, 16'h0000, 16'h0060, 16'h0F0F, 3, 1, 1, '{0, 16'h0050, 2'b11, 16'h0000}, '{0, 16'h0060, 2'b11, 16'h0000}, 1, 16'h0F0F};
    // reset with a memory op presented: outputs must still sit at reset values
    op_valid = 1'b1; opcode = op_ldr; ctrl_mem_read = 1'b1; mem_addr = 16'h0040;
    @(negedge clk);
    #2;
    chk_reset_vals("rst");
    @(negedge clk);
    op_valid = 1'b0; rst_n = 1'b1;
    // a stray response while idle must be ignored
    dmem_resp = 1'b1; dmem_rdata = 16'h9999;
    #2;
    chk("idle_resp_stall", stall, 0);
    chk("idle_resp_load", load_data, 0);
    @(negedge clk);
    dmem_resp = 1'b0;
    // non-memory op passes straight through
    op_valid = 1'b1; opcode = op_add; ctrl_mem_read = 1'b0; ctrl_mem_write = 1'b0;
    #2;
    chk("alu_req", {dmem_read, dmem_write}, 0);
    chk("alu_stall", stall, 0);
    @(negedge clk);
    idle_chk("alu");
    for (int i = 0; i < 10; i++) begin
      run_vec(v[i], 1'b1);
      idle_chk("vec");
    end
    // completion with advance low parks in HOLD and keeps the loaded value
    run_vec('{op_ldr, 1, 0, 16'h0040, 16'h0000, 16'h7777, 16'h0000, 2, 0, 0,
              '{0, 16'h0040, 2'b11, 16'h0000}, '{0, 16'h0000, 2'b11, 16'h0000}, 1, 16'h7777}, 1'b0);
    dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
    #2;
    chk("hold_stall", stall, 0);
    chk("hold_req", {dmem_read, dmem_write}, 0);
    chk("hold_load", load_data, 16'h7777);
    @(negedge clk);
    dmem_resp = 1'b0; advance = 1'b1;
    #2;
    chk("hold_adv_load", load_data, 16'h7777);
    chk("hold_adv_req", {dmem_read, dmem_write}, 0);
    @(negedge clk);
    idle_chk("hold");
    // reset asserted during the second LDI access
    op_valid = 1'b1; opcode = op_ldi; ctrl_mem_read = 1'b1; ctrl_mem_write = 1'b0; mem_addr = 16'h0010;
    #2;
    chk("rldi_a1_addr", dmem_addr, 16'h0010);
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 16'h0200;
    @(negedge clk);
    dmem_resp = 1'b0;
    #2;
    chk("rldi_a2_req", {dmem_read, dmem_addr}, {1'b1, 16'h0200});
    chk("rldi_a2_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rldi_drop_read", dmem_read, 0);
    chk("rldi_drop_stall", stall, 0);
    @(negedge clk);
    op_valid = 1'b0; rst_n = 1'b1;
    #2;
    chk_reset_vals("post_rst");
    @(negedge clk);
    run_vec(v[0], 1'b1);
    idle_chk("post_rst_ldr");
    chk("sb_drain", sb.size() + ld_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
